// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// FIFO results fill idle slots, or are forced in after a bounded wait by stalling the pipe.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  q_addr,
    output logic        q_pending,
    output logic        stall_pipe,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    typedef logic [AW-1:0] ptr_t;

    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [31:0]   rf_data_q, rf_data_d;

    logic pipe_req, fifo_empty, push;
    logic fifo_gnt, pipe_gnt, force_gnt;
    logic hit;

    assign pipe_req   = pipe_we && (pipe_addr != 5'd0);
    assign fifo_empty = (count_q == '0);
    // Ready looks at the pre-pop count, so a full FIFO never accepts in its popping cycle.
    assign lu_ready   = !reset && (count_q < DEPTH_C);
    assign push       = lu_valid && lu_ready && (lu_addr != 5'd0);
    assign stall_pipe = force_gnt && !reset;

    always_comb begin
        fifo_gnt  = 1'b0;
        pipe_gnt  = 1'b0;
        force_gnt = 1'b0;
        if (fifo_empty) begin
            pipe_gnt = pipe_req;
        end else if (!pipe_req) begin
            fifo_gnt = 1'b1;
        end else if (starve_q == STARVE_C) begin
            fifo_gnt  = 1'b1;
            force_gnt = 1'b1;
        end else begin
            pipe_gnt = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = fifo_gnt ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, fifo_gnt})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (fifo_gnt || (count_d == '0)) begin
            starve_d = '0;
        end else if (pipe_gnt && !fifo_empty && (starve_q != STARVE_C)) begin
            starve_d = starve_q + SW'(1);
        end

        rf_we_d   = fifo_gnt || pipe_gnt;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (fifo_gnt) begin
            rf_addr_d = addr_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
        end else if (pipe_gnt) begin
            rf_addr_d = pipe_addr;
            rf_data_d = pipe_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(ptr_t'(ptr_t'(i) - rd_ptr_q)) < count_q) && (addr_mem_q[i] == q_addr)) begin
                hit = 1'b1;
            end
        end
    end

    assign q_pending = hit && (q_addr != 5'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= lu_addr;
            data_mem_q[wr_ptr_q] <= lu_data;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule
